// File: rtl/mix_columns_serial.sv
// ---------------------------------------------------------------------------
// mix_columns_serial
//   Byte-serial AES MixColumns / InvMixColumns stage for the 8-bit datapath.
//   Collects four bytes of a column, transforms them in GF(2^8) on the edge
//   that accepts the fourth byte, then drains the column one byte per cycle.
//   A final-round bypass, sampled with the fourth byte, passes the column
//   through unchanged.
//
// Parameters
//   COLS  columns per state (state = 4*COLS bytes)
//   INV   0: MixColumns {02,03,01,01}, 1: InvMixColumns {0E,0B,0D,09}
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   din         input byte, column-major order
//   din_valid   din is accepted on this edge
//   bypass      column passes through untransformed (sampled with byte 3)
//   flush       synchronous clear of partial column and output drain
//   dout        output byte (0 when not valid)
//   dout_valid  dout holds a valid byte
//   dout_last   dout is the final byte of the state
// ---------------------------------------------------------------------------
module mix_columns_serial #(
  parameter int COLS = 4,
  parameter bit INV  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       bypass,
  input  logic       flush,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_last
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    if (b[7]) begin
      r = {b[6:0], 1'b0} ^ 8'h1B;
    end else begin
      r = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  // Constant multiply built from xtime chains; only the coefficients used
  // by the forward and inverse transforms are supported.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] r;
    x1 = xtime(b);
    x2 = xtime(x1);
    x3 = xtime(x2);
    case (c)
      8'h01:   r = b;
      8'h02:   r = x1;
      8'h03:   r = x1 ^ b;
      8'h09:   r = x3 ^ b;
      8'h0B:   r = x3 ^ x1 ^ b;
      8'h0D:   r = x3 ^ x2 ^ b;
      8'h0E:   r = x3 ^ x2 ^ x1;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Coefficient for circulant position idx = (k - r) mod 4.
  function automatic logic [7:0] coeff(input logic [1:0] idx);
    logic [7:0] c;
    if (INV) begin
      case (idx)
        2'd0:    c = 8'h0E;
        2'd1:    c = 8'h0B;
        2'd2:    c = 8'h0D;
        2'd3:    c = 8'h09;
        default: c = 8'h00;
      endcase
    end else begin
      case (idx)
        2'd0:    c = 8'h02;
        2'd1:    c = 8'h03;
        2'd2:    c = 8'h01;
        2'd3:    c = 8'h01;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  logic [7:0]    buf_r [0:2];
  logic [1:0]    byte_cnt_r;
  logic [CW-1:0] col_cnt_r;
  logic [7:0]    out_r [0:3];
  logic [2:0]    out_cnt_r;
  logic          last_col_r;
  logic [7:0]    dout_r;
  logic          dout_valid_r;
  logic          dout_last_r;

  logic [7:0]    a_s      [0:3];
  logic [7:0]    result_s [0:3];
  logic          accept_s;
  logic          load_s;

  // Flush wins over a same-cycle input byte; a load happens on the 4th byte.
  always_comb begin
    accept_s = din_valid && !flush;
    load_s   = accept_s && (byte_cnt_r == 2'd3);
  end

  // Assemble the column with the live 4th byte so the result is ready at its edge.
  always_comb begin
    a_s[0] = buf_r[0];
    a_s[1] = buf_r[1];
    a_s[2] = buf_r[2];
    a_s[3] = din;
  end

  // Column transform: row r = XOR over k of coeff[(k-r) mod 4] * a[k].
  always_comb begin
    logic [7:0] acc_s;
    acc_s = 8'h00;
    for (int r = 0; r < 4; r++) begin
      acc_s = 8'h00;
      for (int k = 0; k < 4; k++) begin
        acc_s = acc_s ^ gmul(a_s[k], coeff(2'((k - r + 4) % 4)));
      end
      if (bypass) begin
        result_s[r] = a_s[r];
      end else begin
        result_s[r] = acc_s;
      end
    end
  end

  // Input gathering, column counting and output drain. The load is written
  // after the drain so that it overrides the final shift of the previous
  // column on the same edge, giving back-to-back columns without a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      byte_cnt_r   <= 2'd0;
      col_cnt_r    <= {CW{1'b0}};
      out_cnt_r    <= 3'd0;
      last_col_r   <= 1'b0;
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
        out_r[i] <= 8'h00;
      end
    end else begin
      if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    buf_r[0] <= din;
          2'd1:    buf_r[1] <= din;
          2'd2:    buf_r[2] <= din;
          default: ;
        endcase
      end

      if (out_cnt_r != 3'd0) begin
        dout_r       <= out_r[0];
        dout_valid_r <= 1'b1;
        dout_last_r  <= last_col_r && (out_cnt_r == 3'd1);
        out_r[0]     <= out_r[1];
        out_r[1]     <= out_r[2];
        out_r[2]     <= out_r[3];
        out_r[3]     <= 8'h00;
        out_cnt_r    <= out_cnt_r - 3'd1;
      end else begin
        dout_r       <= 8'h00;
        dout_valid_r <= 1'b0;
        dout_last_r  <= 1'b0;
      end

      if (load_s) begin
        for (int i = 0; i < 4; i++) begin
          out_r[i] <= result_s[i];
        end
        out_cnt_r  <= 3'd4;
        last_col_r <= (col_cnt_r == LAST_COL);
        if (col_cnt_r == LAST_COL) begin
          col_cnt_r <= {CW{1'b0}};
        end else begin
          col_cnt_r <= col_cnt_r + CW'(1);
        end
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;

endmodule

// File: tb/tb_mix_columns_serial.sv
module tb_mix_columns_serial;

  localparam int COLS = 4;
  localparam int N    = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       bypass;
  logic       flush;
  logic [7:0] dout_f, dout_i;
  logic       v_f, v_i, l_f, l_i;

  always #5 clk = ~clk;

  mix_columns_serial #(.COLS(COLS), .INV(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .bypass(bypass),
    .flush(flush), .dout(dout_f), .dout_valid(v_f), .dout_last(l_f));

  mix_columns_serial #(.COLS(COLS), .INV(1'b1)) u_inv (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .bypass(bypass),
    .flush(flush), .dout(dout_i), .dout_valid(v_i), .dout_last(l_i));

  int n_cmp = 0;
  int n_bad = 0;

  // expected schedule per edge index
  bit         ev [N];
  bit         el [N];
  logic [7:0] ef [N];
  logic [7:0] ei [N];
  // observations per edge index
  logic [7:0] of_ [N];
  logic [7:0] oi_ [N];
  logic       ov_ [N];
  logic       ol_ [N];

  logic [7:0] col_q [$];
  int         m_col  = 0;
  int         edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply (shift-and-add, reduce by x^8+x^4+x^3+x+1).
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b  = b >> 1;
    end
    return gm_ret(p);
  endfunction

  function automatic logic [7:0] gm_ret(input logic [7:0] p);
    return p;
  endfunction

  // Row r of the (inverse) MixColumns matrix product with column c.
  function automatic logic [7:0] mix(input logic [7:0] c0, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] c3,
                                     input bit inv, input int r);
    logic [7:0] cf [4];
    logic [7:0] a  [4];
    logic [7:0] s;
    if (inv) begin
      cf[0] = 8'h0E; cf[1] = 8'h0B; cf[2] = 8'h0D; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    a[0] = c0; a[1] = c1; a[2] = c2; a[3] = c3;
    s = 8'h00;
    for (int k = 0; k < 4; k++) s = s ^ gm(cf[(k - r + 4) % 4], a[k]);
    return s;
  endfunction

  // One clock: drive inputs, take the edge, update the model, check outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic byp,
                      input logic fl, input logic rs);
    int e;
    din_valid = v; din = d; bypass = byp; flush = fl; rst = rs;
    @(posedge clk);
    e = edge_n;
    if (rs || fl) begin
      col_q.delete();
      m_col = 0;
      for (int j = e; j < N; j++) ev[j] = 1'b0;
    end else if (v) begin
      col_q.push_back(d);
      if (col_q.size() == 4) begin
        for (int r = 0; r < 4; r++) begin
          ev[e+1+r] = 1'b1;
          el[e+1+r] = (m_col == COLS - 1) && (r == 3);
          ef[e+1+r] = byp ? col_q[r] : mix(col_q[0], col_q[1], col_q[2], col_q[3], 1'b0, r);
          ei[e+1+r] = byp ? col_q[r] : mix(col_q[0], col_q[1], col_q[2], col_q[3], 1'b1, r);
        end
        m_col = (m_col + 1) % COLS;
        col_q.delete();
      end
    end
    #1;
    of_[e] = dout_f; oi_[e] = dout_i; ov_[e] = v_f; ol_[e] = l_f;
    chk("valid_fwd", {31'd0, v_f}, {31'd0, ev[e]});
    chk("valid_inv", {31'd0, v_i}, {31'd0, ev[e]});
    chk("dout_fwd",  {24'd0, dout_f}, {24'd0, ev[e] ? ef[e] : 8'h00});
    chk("dout_inv",  {24'd0, dout_i}, {24'd0, ev[e] ? ei[e] : 8'h00});
    chk("last_fwd",  {31'd0, l_f}, {31'd0, ev[e] && el[e]});
    chk("last_inv",  {31'd0, l_i}, {31'd0, ev[e] && el[e]});
    edge_n++;
  endtask

  task automatic col4(input logic [31:0] w, input logic byp);
    step(1'b1, w[31:24], 1'b0, 1'b0, 1'b0);
    step(1'b1, w[23:16], 1'b0, 1'b0, 1'b0);
    step(1'b1, w[15:8],  1'b0, 1'b0, 1'b0);
    step(1'b1, w[7:0],   byp,  1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int e0;
    int e4;
    logic [7:0] exp_f [0:15];
    logic [7:0] exp_i [0:3];
    logic [7:0] exp_b [0:3];
    logic [31:0] w;

    exp_f[0]  = 8'h8e; exp_f[1]  = 8'h4d; exp_f[2]  = 8'ha1; exp_f[3]  = 8'hbc;
    exp_f[4]  = 8'h9f; exp_f[5]  = 8'hdc; exp_f[6]  = 8'h58; exp_f[7]  = 8'h9d;
    exp_f[8]  = 8'hc6; exp_f[9]  = 8'hc6; exp_f[10] = 8'hc6; exp_f[11] = 8'hc6;
    exp_f[12] = 8'h01; exp_f[13] = 8'h01; exp_f[14] = 8'h01; exp_f[15] = 8'h01;
    exp_i[0]  = 8'hdb; exp_i[1]  = 8'h13; exp_i[2]  = 8'h53; exp_i[3]  = 8'h45;
    exp_b[0]  = 8'hdb; exp_b[1]  = 8'h13; exp_b[2]  = 8'h53; exp_b[3]  = 8'h45;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    // full state of known columns, then a second state back-to-back
    e0 = edge_n;
    col4(32'hdb135345, 1'b0);
    col4(32'hf20a225c, 1'b0);
    col4(32'hc6c6c6c6, 1'b0);
    col4(32'h01010101, 1'b0);
    col4(32'h8e4da1bc, 1'b0);
    col4(32'hdb135345, 1'b1);
    col4($urandom, 1'b0);
    col4($urandom, 1'b0);
    idle(6);

    for (int i = 0; i < 16; i++) begin
      chk("known_fwd", {24'd0, of_[e0+4+i]}, {24'd0, exp_f[i]});
      chk("contig_valid", {31'd0, ov_[e0+4+i]}, 32'd1);
      chk("known_last", {31'd0, ol_[e0+4+i]}, {31'd0, (i == 15)});
    end
    for (int i = 0; i < 4; i++) begin
      chk("known_inv", {24'd0, oi_[e0+20+i]}, {24'd0, exp_i[i]});
      chk("bypass_fwd", {24'd0, of_[e0+24+i]}, {24'd0, exp_b[i]});
      chk("bypass_inv", {24'd0, oi_[e0+24+i]}, {24'd0, exp_b[i]});
    end
    chk("no_bubble", {31'd0, ov_[e0+20]}, 32'd1);

    // gaps of one idle cycle between bytes
    w = $urandom;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[31-8*i -: 8], 1'b0, 1'b0, 1'b0);
      if (i < 3) idle(1);
    end
    e4 = edge_n - 1;
    idle(6);
    chk("gap_start_idle", {31'd0, ov_[e4]}, 32'd0);
    chk("gap_start", {31'd0, ov_[e4+1]}, 32'd1);

    // flush after 2 bytes, then a fresh column
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    col4(32'hdb135345, 1'b0);
    idle(5);
    chk("after_flush", {24'd0, of_[edge_n-5]}, 32'h8e);

    // reset after 2 bytes, then a fresh column
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", {31'd0, ov_[edge_n-1]}, 32'd0);
    col4(32'h8e4da1bc, 1'b0);
    idle(5);
    chk("after_rst", {24'd0, oi_[edge_n-5]}, 32'hdb);

    // flush in the middle of a drain, with a same-cycle byte
    col4($urandom, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
